// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, function codes,
// ALU operation codes and the main-decoder to ALU-decoder ALUOp field.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational D-stage decode: main decoder produces the control flags and an
// ALUOp class, the ALU decoder refines it with Funct for R-type instructions.
module ctrl_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       regWrite,
    output logic       memToReg,
    output logic       memWrite,
    output logic       branch,
    output logic       jump,
    output logic       aluSrc,
    output logic       regDst,
    output logic [2:0] aluControl
);

    logic   mainRegWrite;
    logic   functOk;
    aluop_t aluOp;

    always_comb begin
        mainRegWrite = 1'b0;
        memToReg     = 1'b0;
        memWrite     = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        aluSrc       = 1'b0;
        regDst       = 1'b0;
        aluOp        = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                mainRegWrite = 1'b1;
                regDst       = 1'b1;
                aluOp        = ALUOP_FUNCT;
            end
            OP_LW: begin
                mainRegWrite = 1'b1;
                aluSrc       = 1'b1;
                memToReg     = 1'b1;
            end
            OP_SW: begin
                aluSrc   = 1'b1;
                memWrite = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                aluOp  = ALUOP_SUB;
            end
            OP_ADDI: begin
                mainRegWrite = 1'b1;
                aluSrc       = 1'b1;
            end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        aluControl = ALU_ADD;
        functOk    = 1'b1;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD: aluControl = ALU_ADD;
                    F_SUB: aluControl = ALU_SUB;
                    F_AND: aluControl = ALU_AND;
                    F_OR:  aluControl = ALU_OR;
                    F_SLT: aluControl = ALU_SLT;
                    default: begin
                        aluControl = ALU_AND;
                        functOk    = 1'b0;
                    end
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

    // An unknown R-type function must not write the register file.
    assign regWrite = mainRegWrite & functOk;

endmodule

// File: rtl/pipelined_controller.sv
// MIPS pipeline control unit: D-stage decode plus the E/M/W control registers,
// with the hazard unit's FlushE turning the instruction entering E into a bubble.
module pipelined_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH   = 6,
    parameter int ALUC_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_WIDTH-1:0]   Opcode,
    input  logic [OP_WIDTH-1:0]   Funct,
    input  logic                  EqualD,
    input  logic                  FlushE,
    output logic                  BranchD,
    output logic                  JumpD,
    output logic                  PCSrcD,
    output logic                  RegWriteE,
    output logic                  MemToRegE,
    output logic                  RegDstE,
    output logic                  ALUSrcE,
    output logic [ALUC_WIDTH-1:0] ALUControlE,
    output logic                  RegWriteM,
    output logic                  MemToRegM,
    output logic                  MemWriteM,
    output logic                  RegWriteW,
    output logic                  MemToRegW
);

    logic                  regWriteD;
    logic                  memToRegD;
    logic                  memWriteD;
    logic                  aluSrcD;
    logic                  regDstD;
    logic [ALUC_WIDTH-1:0] aluControlD;
    logic                  memWriteE;

    ctrl_decoder u_decoder (
        .opcode     (Opcode),
        .funct      (Funct),
        .regWrite   (regWriteD),
        .memToReg   (memToRegD),
        .memWrite   (memWriteD),
        .branch     (BranchD),
        .jump       (JumpD),
        .aluSrc     (aluSrcD),
        .regDst     (regDstD),
        .aluControl (aluControlD)
    );

    assign PCSrcD = BranchD & EqualD;

    // Reset clears every stage on the same edge; FlushE only squashes E.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteE   <= 1'b0;
            MemToRegE   <= 1'b0;
            memWriteE   <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            RegWriteM   <= 1'b0;
            MemToRegM   <= 1'b0;
            MemWriteM   <= 1'b0;
            RegWriteW   <= 1'b0;
            MemToRegW   <= 1'b0;
        end else begin
            if (FlushE) begin
                RegWriteE   <= 1'b0;
                MemToRegE   <= 1'b0;
                memWriteE   <= 1'b0;
                ALUControlE <= '0;
                ALUSrcE     <= 1'b0;
                RegDstE     <= 1'b0;
            end else begin
                RegWriteE   <= regWriteD;
                MemToRegE   <= memToRegD;
                memWriteE   <= memWriteD;
                ALUControlE <= aluControlD;
                ALUSrcE     <= aluSrcD;
                RegDstE     <= regDstD;
            end
            RegWriteM <= RegWriteE;
            MemToRegM <= MemToRegE;
            MemWriteM <= memWriteE;
            RegWriteW <= RegWriteM;
            MemToRegW <= MemToRegM;
        end
    end

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: instruction-level model of decode and stage
// occupancy checked every cycle, plus directed literal expectations.
module tb_pipelined_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       EqualD = 1'b0;
    logic       FlushE = 1'b0;
    logic       BranchD, JumpD, PCSrcD;
    logic       RegWriteE, MemToRegE, RegDstE, ALUSrcE;
    logic [2:0] ALUControlE;
    logic       RegWriteM, MemToRegM, MemWriteM;
    logic       RegWriteW, MemToRegW;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    pipelined_controller dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .EqualD(EqualD), .FlushE(FlushE),
        .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .RegDstE(RegDstE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW)
    );

    // What an instruction asks of the pipeline, independent of how it is staged.
    typedef struct packed {
        logic       rw;
        logic       m2r;
        logic       mw;
        logic       br;
        logic       jmp;
        logic       src;
        logic       dst;
        logic [2:0] alu;
    } ctl_t;

    function automatic ctl_t decode(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        c.alu = 3'b010;
        if (op == 6'b000000) begin
            c.dst = 1'b1;
            c.rw  = 1'b1;
            if      (fn == 6'b100000) c.alu = 3'b010;
            else if (fn == 6'b100010) c.alu = 3'b110;
            else if (fn == 6'b100100) c.alu = 3'b000;
            else if (fn == 6'b100101) c.alu = 3'b001;
            else if (fn == 6'b101010) c.alu = 3'b111;
            else begin c.alu = 3'b000; c.rw = 1'b0; end
        end else if (op == 6'b100011) begin
            c.rw = 1'b1; c.src = 1'b1; c.m2r = 1'b1;
        end else if (op == 6'b101011) begin
            c.src = 1'b1; c.mw = 1'b1;
        end else if (op == 6'b000100) begin
            c.br = 1'b1; c.alu = 3'b110;
        end else if (op == 6'b001000) begin
            c.rw = 1'b1; c.src = 1'b1;
        end else if (op == 6'b000010) begin
            c.jmp = 1'b1;
        end
        return c;
    endfunction

    // Which instruction occupies each stage; a bubble is an all-zero record.
    ctl_t inE = '0, inM = '0, inW = '0;
    int   edges = 0;

    always @(posedge clk) begin
        edges <= edges + 1;
        if (reset) begin
            inE <= '0; inM <= '0; inW <= '0;
        end else begin
            inE <= FlushE ? ctl_t'('0) : decode(Opcode, Funct);
            inM <= inE;
            inW <= inM;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nCompared = nCompared + 1;
        if (act !== exp) begin
            nMismatched = nMismatched + 1;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ctl_t d;
        if (edges > 0) begin
            d = decode(Opcode, Funct);
            if (!$isunknown({Opcode, Funct, EqualD})) begin
                chk("BranchD", 8'(BranchD), 8'(d.br));
                chk("JumpD",   8'(JumpD),   8'(d.jmp));
                chk("PCSrcD",  8'(PCSrcD),  8'(d.br & EqualD));
            end
            chk("RegWriteE",   8'(RegWriteE),   8'(inE.rw));
            chk("MemToRegE",   8'(MemToRegE),   8'(inE.m2r));
            chk("RegDstE",     8'(RegDstE),     8'(inE.dst));
            chk("ALUSrcE",     8'(ALUSrcE),     8'(inE.src));
            chk("ALUControlE", 8'(ALUControlE), 8'(inE.alu));
            chk("RegWriteM",   8'(RegWriteM),   8'(inM.rw));
            chk("MemToRegM",   8'(MemToRegM),   8'(inM.m2r));
            chk("MemWriteM",   8'(MemWriteM),   8'(inM.mw));
            chk("RegWriteW",   8'(RegWriteW),   8'(inW.rw));
            chk("MemToRegW",   8'(MemToRegW),   8'(inW.m2r));
            $display("cycle %0d op=%b fn=%b rst=%b fl=%b E=%b%b%b%b/%b M=%b%b%b W=%b%b",
                     edges, Opcode, Funct, reset, FlushE, RegWriteE, MemToRegE,
                     RegDstE, ALUSrcE, ALUControlE, RegWriteM, MemToRegM, MemWriteM,
                     RegWriteW, MemToRegW);
        end
    end

    // Present one instruction, take the edge, and settle just past it.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic eq, input logic fl);
        reset = r; Opcode = op; Funct = fn; EqualD = eq; FlushE = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] NOP = 6'b111111;
    logic [5:0] sweepFn [6];
    logic [2:0] sweepAlu [6];
    logic       sweepRw [6];

    initial begin
        sweepFn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        sweepAlu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b000};
        sweepRw  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset, first with unknown inputs, then with an add presented.
        cyc(1'b1, 6'bxxxxxx, 6'bxxxxxx, 1'bx, 1'bx);
        chk("rst_x_RegWriteE", 8'(RegWriteE), 8'd0);
        chk("rst_x_ALUControlE", 8'(ALUControlE), 8'd0);
        cyc(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b0);
        cyc(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b0);
        chk("rst_RegWriteE", 8'(RegWriteE), 8'd0);
        chk("rst_RegWriteW", 8'(RegWriteW), 8'd0);
        cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0);
        chk("rel_RegWriteE", 8'(RegWriteE), 8'd1);
        chk("rel_RegDstE", 8'(RegDstE), 8'd1);
        chk("rel_ALUControlE", 8'(ALUControlE), 8'b010);

        // lw flowing through E, M, W and out.
        cyc(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b0);
        chk("lw_E", 8'({ALUSrcE, MemToRegE, RegWriteE}), 8'b111);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        chk("lw_M", 8'({MemToRegM, RegWriteM, MemWriteM}), 8'b110);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        chk("lw_W", 8'({RegWriteW, MemToRegW}), 8'b11);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        chk("lw_gone", 8'({RegWriteE, MemToRegE, RegWriteM, MemToRegM, RegWriteW, MemToRegW}), 8'd0);

        // sw reaches M two edges after it is decoded.
        cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0);
        chk("sw_M_early", 8'(MemWriteM), 8'd0);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        chk("sw_M", 8'(MemWriteM), 8'd1);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        chk("sw_M_after", 8'(MemWriteM), 8'd0);
        chk("sw_W", 8'(RegWriteW), 8'd0);

        // beq: branch resolution is combinational in D.
        Opcode = 6'b000100; EqualD = 1'b1;
        #1;
        chk("beq_PCSrcD_eq", 8'(PCSrcD), 8'd1);
        EqualD = 1'b0;
        #1;
        chk("beq_PCSrcD_ne", 8'(PCSrcD), 8'd0);
        cyc(1'b0, 6'b000100, 6'b000000, 1'b0, 1'b0);
        chk("beq_ALUControlE", 8'(ALUControlE), 8'b110);
        cyc(1'b0, 6'b000010, 6'b000000, 1'b1, 1'b0);
        chk("j_RegWriteE", 8'(RegWriteE), 8'd0);

        // Flushed sub behind an add: the add still retires.
        cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0);
        cyc(1'b0, 6'b000000, 6'b100010, 1'b0, 1'b1);
        chk("flush_E", 8'({RegWriteE, MemToRegE, RegDstE, ALUSrcE, ALUControlE}), 8'd0);
        chk("flush_add_M", 8'(RegWriteM), 8'd1);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        chk("flush_add_W", 8'(RegWriteW), 8'd1);
        chk("flush_sub_M", 8'(RegWriteM), 8'd0);

        // Funct sweep, ending with an illegal function code.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 6'b000000, sweepFn[i], 1'b0, 1'b0);
            chk("sweep_ALUControlE", 8'(ALUControlE), 8'(sweepAlu[i]));
            chk("sweep_RegWriteE", 8'(RegWriteE), 8'(sweepRw[i]));
        end

        // Reset together with FlushE in the middle of a lw/add/sw stream.
        cyc(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b0);
        cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0);
        cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0);
        cyc(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b1);
        chk("rstfl_E", 8'({RegWriteE, MemToRegE, RegDstE, ALUSrcE, ALUControlE}), 8'd0);
        chk("rstfl_M", 8'({RegWriteM, MemToRegM, MemWriteM}), 8'd0);
        chk("rstfl_W", 8'({RegWriteW, MemToRegW}), 8'd0);
        cyc(1'b0, 6'b001000, 6'b000000, 1'b0, 1'b0);
        chk("post_addi_E", 8'({RegWriteE, ALUSrcE, RegDstE, ALUControlE}), 8'b11_0_010);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        cyc(1'b0, NOP, 6'b000000, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Control unit for the 5-stage pipelined MIPS core, on the other side of the datapath's control interface.
- Consumes Opcode/Funct and EqualD from the datapath's Decode stage. Produces per-stage control signals (D, E, M, W) that feed the datapath's control inputs.
- Contains the E/M/W control pipeline registers, with an E-stage flush driven by the hazard unit.

Parameters:
- OP_WIDTH, 6, width of Opcode and Funct fields.
- ALUC_WIDTH, 3, width of ALUControl.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- Opcode  input  6  instr[31:26] in D stage.
- Funct  input  6  instr[5:0] in D stage.
- EqualD  input  1  register-compare result in D stage.
- FlushE  input  1  from hazard unit; bubbles the E-stage control registers.
- BranchD  output  1  beq decoded in D.
- JumpD  output  1  j decoded in D.
- PCSrcD  output  1  BranchD & EqualD.
- RegWriteE  output  1  E-stage copy, for the hazard unit.
- MemToRegE  output  1  E-stage copy, for the hazard unit.
- RegDstE  output  1  1 = rd, 0 = rt.
- ALUSrcE  output  1  1 = sign-extended immediate.
- ALUControlE  output  3  ALU operation.
- RegWriteM  output  1  M-stage copy.
- MemToRegM  output  1  M-stage copy.
- MemWriteM  output  1  data-memory write enable.
- RegWriteW  output  1  W-stage register-file write enable.
- MemToRegW  output  1  1 = write back read data.

Behaviour:
- D stage, combinational decode of Opcode:
  - 000000 R-type: RegWrite=1, RegDst=1, ALUOp=10.
  - 100011 lw: RegWrite=1, ALUSrc=1, MemToReg=1, ALUOp=00.
  - 101011 sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 000100 beq: Branch=1, ALUOp=01.
  - 001000 addi: RegWrite=1, ALUSrc=1, ALUOp=00.
  - 000010 j: Jump=1.
  - Any other opcode: all controls 0 (nop).
- ALU decode:
  - ALUOp=00 -> 010.
  - ALUOp=01 -> 110.
  - ALUOp=10 by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other Funct -> 000 with RegWrite forced to 0 (illegal instruction becomes a nop).
- D-stage outputs: BranchD, JumpD and PCSrcD are combinational from the current inputs, with zero latency.
- E register, updated on posedge clk:
  - Loads RegWrite, MemToReg, MemWrite, ALUControl, ALUSrc, RegDst.
  - If reset or FlushE, all E fields load 0; reset and FlushE together give the same result.
- M register: loads RegWriteE, MemToRegE, MemWriteE one cycle after E. The MemWrite E copy is internal only.
- W register: loads RegWriteM and MemToRegM one cycle after M.
- Latency from decode: E = 1 cycle, M = 2 cycles, W = 3 cycles.
- Flush semantics: only the instruction entering E is squashed. Instructions already in M and W complete normally.
- No stall input on E/M/W. The hazard unit stalls F/D in the datapath and flushes E; the bubble propagates as zeros.
- Reset:
  - Every registered output is 0 on the edge where reset is sampled high.
  - Reset asserted mid-stream clears all three stages in that same edge; there is no partial drain.
  - D-stage combinational outputs are unaffected by reset.
- Inputs X/Z during reset: registered outputs must still be 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT.
  - ALUControl constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
  - ALUOp encodings.
- One sub-module, ctrl_decoder: purely combinational main decoder plus ALU decoder, producing the D-stage control bundle.
- The top level holds only the E/M/W registers and the PCSrcD gate.

Test Plan:
- Reset: hold reset for 2 cycles with Opcode=000000, Funct=100000 -> all E/M/W outputs 0. Release reset -> next edge gives RegWriteE=1, RegDstE=1, ALUControlE=010.
- lw pipeline: Opcode=100011 for 1 cycle, then 111111 (nop) ->
  - cycle+1: ALUSrcE=1, MemToRegE=1, RegWriteE=1.
  - cycle+2: MemToRegM=1, RegWriteM=1, MemWriteM=0.
  - cycle+3: RegWriteW=1, MemToRegW=1.
  - cycle+4: all zeros.
- sw then beq:
  - Opcode=101011 -> MemWriteM=1 exactly 2 cycles later, RegWriteW=0.
  - Opcode=000100 with EqualD=1 -> PCSrcD=1 in the same cycle; EqualD=0 -> PCSrcD=0. ALUControlE=110 the following cycle.
- Flush: R-type sub (Funct=100010) with FlushE=1 on that edge -> E fields all 0, ALUControlE=000. An older add already in M still gives RegWriteW=1 one cycle later.
- Funct sweep: R-type with Funct 100000/100010/100100/100101/101010 -> ALUControlE 010/110/000/001/111. Funct=000000 -> RegWriteE=0.
- Simultaneous reset+FlushE during a lw/add/sw stream -> all stages 0 after 1 edge. Next instruction after release appears normally at E.
